// File: rtl/loader_pkg.sv
// Shared definitions for the boot-image loader: FSM encoding and frame geometry.
package loader_pkg;
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; pulses o_word_valid on the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);
  logic [31:0] r_shift;
  logic [1:0]  r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (i_en) begin
      r_shift <= {i_byte, r_shift[31:8]};
      r_idx   <= r_idx + 2'd1;
    end
  end

  // Word is presented combinationally alongside the final byte so the top can register it.
  assign o_word       = {i_byte, r_shift[31:8]};
  assign o_word_valid = i_en && (r_idx == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/prog_loader.sv
// Host-link boot loader: parses a counted, XOR-checked frame into instruction memory, then releases the CPU.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        done,
  output logic        error
);
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt_lo, r_csum;
  logic [15:0] r_count, r_word_cnt;
  logic [15:0] w_count_hdr;
  logic [31:0] w_word;
  logic        w_xfer, w_asm_en, w_word_valid;

  assign rx_ready    = !rst && (r_state inside {S_HDR0, S_HDR1, S_DATA, S_CSUM});
  assign w_xfer      = rx_valid && rx_ready;
  assign w_asm_en    = w_xfer && (r_state == S_DATA);
  assign w_count_hdr = {rx_data, r_cnt_lo};

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .i_en         (w_asm_en),
    .i_byte       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR0;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0: if (w_xfer) w_next = S_HDR1;
      S_HDR1: if (w_xfer) begin
        if (w_count_hdr == 16'd0)              w_next = S_CSUM;
        else if ({1'b0, w_count_hdr} > MAXW)   w_next = S_ERROR;
        else                                   w_next = S_DATA;
      end
      S_DATA: if (w_word_valid && (r_word_cnt == r_count - 16'd1)) w_next = S_CSUM;
      S_CSUM: if (w_xfer) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= ADDR_BASE;
      imem_wdata <= '0;
      r_cnt_lo   <= '0;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_csum     <= '0;
    end else begin
      imem_we <= w_word_valid;
      if (w_word_valid) begin
        imem_addr  <= ADDR_BASE + {14'd0, r_word_cnt, 2'b00};
        imem_wdata <= w_word;
        r_word_cnt <= r_word_cnt + 16'd1;
      end
      if (w_xfer && (r_state == S_HDR0)) r_cnt_lo <= rx_data;
      if (w_xfer && (r_state == S_HDR1)) r_count  <= w_count_hdr;
      if (w_asm_en)                      r_csum   <= r_csum ^ rx_data;
    end
  end

  assign done    = (r_state == S_DONE);
  assign error   = (r_state == S_ERROR);
  assign cpu_run = done;
endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: good/bad checksum, empty and oversize frames, gaps, mid-frame reset.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, cpu_run, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  int base;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  prog_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_we) begin
      wr_addr[wr_total % 64] <= imem_addr;
      wr_data[wr_total % 64] <= imem_wdata;
      wr_total               <= wr_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is always at posedge+1; returns at posedge+1 after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 8) begin @(posedge clk); #1; t++; end
    if (!rx_ready) chk("ready_timeout", {31'd0, rx_ready}, 32'd1);
    else begin @(posedge clk); #1; end
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int maxgap);
    foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_rx_ready_during", {31'd0, rx_ready}, 32'd0);
    chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk("rst_flags", {29'd0, cpu_run, done, error}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rx_ready_after", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [7:0] f[$];
    @(posedge clk); #1;

    // A: N=2, good checksum 93^13^01^10 = 91, back-to-back
    do_reset();
    base = wr_total;
    send_frame('{8'h02, 8'h00, 8'h93, 8'h00, 8'h00}, 0);
    send_byte(8'h00, 0);
    chk("A_latency_we", {31'd0, imem_we}, 32'd1);
    chk("A_latency_addr", imem_addr, 32'h0);
    chk("A_latency_data", imem_wdata, 32'h0000_0093);
    send_byte(8'h13, 0);
    chk("A_we_drop", {31'd0, imem_we}, 32'd0);
    chk("A_addr_hold", imem_addr, 32'h0);
    chk("A_data_hold", imem_wdata, 32'h0000_0093);
    send_frame('{8'h01, 8'h10, 8'h00, 8'h91}, 0);
    idle(2);
    chk("A_wr_count", 32'(wr_total - base), 32'd2);
    chk("A_addr0", wr_addr[base % 64], 32'h0);
    chk("A_data0", wr_data[base % 64], 32'h0000_0093);
    chk("A_addr1", wr_addr[(base + 1) % 64], 32'h4);
    chk("A_data1", wr_data[(base + 1) % 64], 32'h0010_0113);
    chk("A_flags", {28'd0, rx_ready, cpu_run, done, error}, 32'b0110);
    rx_valid = 1'b1; rx_data = 8'h55;
    idle(3);
    rx_valid = 1'b0;
    chk("A_extra_ignored_wr", 32'(wr_total - base), 32'd2);
    chk("A_extra_ignored_flags", {29'd0, cpu_run, done, error}, 32'b110);

    // B: same frame, wrong checksum
    do_reset();
    base = wr_total;
    send_frame('{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h81}, 0);
    idle(2);
    chk("B_wr_count", 32'(wr_total - base), 32'd2);
    chk("B_data1", wr_data[(base + 1) % 64], 32'h0010_0113);
    chk("B_flags", {28'd0, rx_ready, cpu_run, done, error}, 32'b0001);
    rx_valid = 1'b1; rx_data = 8'hAA;
    idle(6);
    rx_valid = 1'b0;
    chk("B_no_more_writes", 32'(wr_total - base), 32'd2);
    chk("B_error_held", {31'd0, error}, 32'd1);

    // C: empty image
    do_reset();
    base = wr_total;
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    idle(2);
    chk("C_wr_count", 32'(wr_total - base), 32'd0);
    chk("C_flags", {29'd0, cpu_run, done, error}, 32'b110);

    // D: oversize count 65 rejected right after COUNT_HI
    do_reset();
    base = wr_total;
    send_frame('{8'h41, 8'h00}, 0);
    chk("D_error_after_hdr", {28'd0, rx_ready, cpu_run, done, error}, 32'b0001);
    rx_valid = 1'b1; rx_data = 8'h11;
    idle(6);
    rx_valid = 1'b0;
    chk("D_wr_count", 32'(wr_total - base), 32'd0);

    // E: N=1 with random gaps; EF^BE^AD^DE = 22
    do_reset();
    base = wr_total;
    f = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame(f, 5);
    idle(2);
    chk("E_wr_count", 32'(wr_total - base), 32'd1);
    chk("E_addr0", wr_addr[base % 64], 32'h0);
    chk("E_data0", wr_data[base % 64], 32'hDEAD_BEEF);
    chk("E_done", {29'd0, cpu_run, done, error}, 32'b110);

    // F: reset collides with the 4th payload byte, then a fresh N=1 frame; 78^56^34^12 = 08
    do_reset();
    base = wr_total;
    send_frame('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC}, 0);
    rx_valid = 1'b1; rx_data = 8'hDD; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rx_valid = 1'b0;
    chk("F_pending_suppressed", {31'd0, imem_we}, 32'd0);
    idle(1);
    chk("F_no_write_after_rst", 32'(wr_total - base), 32'd0);
    send_frame('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 0);
    idle(2);
    chk("F_wr_count", 32'(wr_total - base), 32'd1);
    chk("F_addr0", wr_addr[base % 64], 32'h0);
    chk("F_data0", wr_data[base % 64], 32'h1234_5678);
    chk("F_done", {29'd0, cpu_run, done, error}, 32'b110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
